// File: rtl/framebuffer_arbiter.sv
// Round-robin arbiter sharing the framebuffer BRAM write port among ray-marcher cores.
// Define FB_DOUBLE_BUFFER_EN for double buffering with vsync-aligned bank swaps.
module framebuffer_arbiter #(
  parameter int unsigned NUM_CORES = 4,
  parameter int unsigned PIXELS    = 76800,
  parameter int unsigned ADDR_BITS = 17
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [NUM_CORES-1:0]                req_valid_in,
  input  logic [NUM_CORES-1:0][ADDR_BITS-1:0] req_addr_in,
  input  logic [NUM_CORES-1:0][3:0]           req_data_in,
  output logic [NUM_CORES-1:0]                req_ready_out,
  input  logic                                vsync_in,
  output logic                                wr_en_out,
  output logic [ADDR_BITS:0]                  wr_addr_out,
  output logic [3:0]                          wr_data_out,
  output logic                                rd_bank_out,
  output logic                                frame_done_out,
  output logic [7:0]                          frame_count_out
);

  localparam int unsigned PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned SCAN_W = PTR_W + 1;
  localparam int unsigned CNT_W  = ADDR_BITS + 1;
  localparam int unsigned DATA_W = 4;

`ifdef FB_DOUBLE_BUFFER_EN
  localparam logic RD_BANK_RST = 1'b1;
  typedef enum logic {ST_RUN = 1'b0, ST_WAIT_VSYNC = 1'b1} state_t;
`else
  localparam logic RD_BANK_RST = 1'b0;
  typedef enum logic {ST_RUN = 1'b0} state_t;
`endif

  state_t              state, state_nxt;
  logic [PTR_W-1:0]    ptr, ptr_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                bank, bank_nxt;
  logic                wr_en_nxt;
  logic [ADDR_BITS:0]  wr_addr_nxt;
  logic [DATA_W-1:0]   wr_data_nxt;
  logic                frame_done_nxt;
  logic [7:0]          frame_count_nxt;

  logic [NUM_CORES-1:0] grant;
  logic                 grant_any;
  logic [PTR_W-1:0]     grant_idx;
  logic [SCAN_W-1:0]    scan_idx;
  logic [ADDR_BITS-1:0] sel_addr;
  logic [DATA_W-1:0]    sel_data;

`ifdef FB_DOUBLE_BUFFER_EN
  logic vsync_d;
  logic vsync_rise;

  assign vsync_rise = vsync_in & ~vsync_d;

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      vsync_d <= 1'b0;
    end else begin
      vsync_d <= vsync_in;
    end
  end
`else
  logic unused_vsync;
  assign unused_vsync = vsync_in;
`endif

  // First valid requester at or after ptr, wrapping modulo NUM_CORES; no grants while stalled.
  always_comb begin
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (state == ST_RUN) begin
      for (int unsigned k = 0; k < NUM_CORES; k++) begin
        scan_idx = {1'b0, ptr} + SCAN_W'(k);
        if (scan_idx >= SCAN_W'(NUM_CORES)) begin
          scan_idx = scan_idx - SCAN_W'(NUM_CORES);
        end
        if (!grant_any && req_valid_in[scan_idx[PTR_W-1:0]]) begin
          grant_any                    = 1'b1;
          grant_idx                    = scan_idx[PTR_W-1:0];
          grant[scan_idx[PTR_W-1:0]]   = 1'b1;
        end
      end
    end
  end

  assign req_ready_out = grant;
  assign sel_addr      = req_addr_in[grant_idx];
  assign sel_data      = req_data_in[grant_idx];

  // Next-state: transfer bookkeeping, frame completion and bank swap.
  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    cnt_nxt         = cnt;
    bank_nxt        = bank;
    wr_en_nxt       = 1'b0;
    wr_addr_nxt     = wr_addr_out;
    wr_data_nxt     = wr_data_out;
    frame_done_nxt  = 1'b0;
    frame_count_nxt = frame_count_out;

    if (grant_any) begin
      ptr_nxt     = (grant_idx == PTR_W'(NUM_CORES - 1)) ? '0 : grant_idx + PTR_W'(1);
      // Out-of-range pixels are consumed and counted so a stray core cannot stall the frame.
      wr_en_nxt   = ({1'b0, sel_addr} < CNT_W'(PIXELS));
      wr_addr_nxt = {bank, sel_addr};
      wr_data_nxt = sel_data;
      if (cnt == CNT_W'(PIXELS - 1)) begin
        cnt_nxt = '0;
`ifdef FB_DOUBLE_BUFFER_EN
        state_nxt = ST_WAIT_VSYNC;
`else
        frame_done_nxt  = 1'b1;
        frame_count_nxt = frame_count_out + 8'd1;
`endif
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end

`ifdef FB_DOUBLE_BUFFER_EN
    // Edges during RUN (including the final-transfer cycle) are deliberately ignored.
    if ((state == ST_WAIT_VSYNC) && vsync_rise) begin
      bank_nxt        = ~bank;
      frame_done_nxt  = 1'b1;
      frame_count_nxt = frame_count_out + 8'd1;
      state_nxt       = ST_RUN;
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state           <= ST_RUN;
      ptr             <= '0;
      cnt             <= '0;
      bank            <= 1'b0;
      wr_en_out       <= 1'b0;
      wr_addr_out     <= '0;
      wr_data_out     <= '0;
      rd_bank_out     <= RD_BANK_RST;
      frame_done_out  <= 1'b0;
      frame_count_out <= '0;
    end else begin
      state           <= state_nxt;
      ptr             <= ptr_nxt;
      cnt             <= cnt_nxt;
      bank            <= bank_nxt;
      wr_en_out       <= wr_en_nxt;
      wr_addr_out     <= wr_addr_nxt;
      wr_data_out     <= wr_data_nxt;
      rd_bank_out     <= RD_BANK_RST ^ bank_nxt;
      frame_done_out  <= frame_done_nxt;
      frame_count_out <= frame_count_nxt;
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// Bench for framebuffer_arbiter: directed steps plus random traffic against a
// frame-level reference model; follows FB_DOUBLE_BUFFER_EN like the design.
module tb_framebuffer_arbiter;

  localparam int unsigned NC  = 4;
  localparam int unsigned PIX = 16;
  localparam int unsigned AB  = 5;
`ifdef FB_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic                  clk_in = 1'b0;
  logic                  rst_n_in;
  logic [NC-1:0]         req_valid_in;
  logic [NC-1:0][AB-1:0] req_addr_in;
  logic [NC-1:0][3:0]    req_data_in;
  logic [NC-1:0]         req_ready_out;
  logic                  vsync_in;
  logic                  wr_en_out;
  logic [AB:0]           wr_addr_out;
  logic [3:0]            wr_data_out;
  logic                  rd_bank_out;
  logic                  frame_done_out;
  logic [7:0]            frame_count_out;

  framebuffer_arbiter #(.NUM_CORES(NC), .PIXELS(PIX), .ADDR_BITS(AB)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .req_valid_in    (req_valid_in),
    .req_addr_in     (req_addr_in),
    .req_data_in     (req_data_in),
    .req_ready_out   (req_ready_out),
    .vsync_in        (vsync_in),
    .wr_en_out       (wr_en_out),
    .wr_addr_out     (wr_addr_out),
    .wr_data_out     (wr_data_out),
    .rd_bank_out     (rd_bank_out),
    .frame_done_out  (frame_done_out),
    .frame_count_out (frame_count_out)
  );

  always #5 clk_in = ~clk_in;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  // Reference model: frame-level view of the arbiter (reset values to start).
  int m_ptr    = 0;
  int m_cnt    = 0;
  int m_bank   = 0;
  int m_fc     = 0;
  int m_frames = 0;
  bit m_wait   = 1'b0;
  bit m_vsd    = 1'b0;
  bit e_wr_en  = 1'b0;
  bit e_fd     = 1'b0;
  int e_wr_addr = 0;
  int e_wr_data = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NC-1:0] exp_grant();
    logic [NC-1:0] g;
    g = '0;
    if (!m_wait) begin
      for (int k = 0; k < NC; k++) begin
        int idx;
        idx = (m_ptr + k) % NC;
        if (req_valid_in[2'(idx)]) begin
          g[2'(idx)] = 1'b1;
          break;
        end
      end
    end
    return g;
  endfunction

  task automatic model_update(input logic [NC-1:0] g);
    bit was_wait;
    int gi;
    was_wait = m_wait;
    e_wr_en  = 1'b0;
    e_fd     = 1'b0;
    if (!rst_n_in) begin
      m_ptr = 0; m_cnt = 0; m_bank = 0; m_wait = 1'b0; m_vsd = 1'b0; m_fc = 0;
      e_wr_addr = 0; e_wr_data = 0;
    end else begin
      if (g != '0) begin
        gi = 0;
        for (int i = 0; i < NC; i++) if (g[2'(i)]) gi = i;
        m_ptr     = (gi + 1) % NC;
        e_wr_en   = (int'(req_addr_in[2'(gi)]) < PIX);
        e_wr_addr = m_bank * (2 ** AB) + int'(req_addr_in[2'(gi)]);
        e_wr_data = int'(req_data_in[2'(gi)]);
        m_cnt++;
        if (m_cnt == PIX) begin
          m_cnt = 0;
          m_frames++;
          if (DB) m_wait = 1'b1;
          else begin
            e_fd = 1'b1;
            m_fc = (m_fc + 1) % 256;
          end
        end
      end
      if (DB && was_wait && vsync_in && !m_vsd) begin
        m_bank = 1 - m_bank;
        e_fd   = 1'b1;
        m_fc   = (m_fc + 1) % 256;
        m_wait = 1'b0;
      end
      m_vsd = vsync_in;
    end
  endtask

  // One clock: check the current cycle against the model, then advance both.
  task automatic tick(output int xfer);
    logic [NC-1:0] g;
    #1;
    g    = exp_grant();
    xfer = (g != '0) ? 1 : 0;
    if (chk_on) begin
      chk("ready", 32'(req_ready_out), 32'(g));
      chk("wr_en", 32'(wr_en_out), 32'(e_wr_en));
      if (e_wr_en) begin
        chk("wr_addr", 32'(wr_addr_out), e_wr_addr);
        chk("wr_data", 32'(wr_data_out), e_wr_data);
      end
      chk("rd_bank", 32'(rd_bank_out), (DB && m_bank == 0) ? 32'd1 : 32'd0);
      chk("frame_done", 32'(frame_done_out), 32'(e_fd));
      chk("frame_count", 32'(frame_count_out), m_fc);
    end
    @(posedge clk_in);
    model_update(g);
    @(negedge clk_in);
  endtask

  task automatic rand_reqs(input int max_addr);
    req_valid_in = 4'($urandom);
    for (int i = 0; i < NC; i++) begin
      req_addr_in[2'(i)] = 5'($urandom_range(0, max_addr));
      req_data_in[2'(i)] = 4'($urandom);
    end
  endtask

  initial begin
    int x;
    int nx;
    int f0;
    rst_n_in     = 1'b0;
    req_valid_in = '0;
    req_addr_in  = '0;
    req_data_in  = '0;
    vsync_in     = 1'b0;

    // Reset held: outputs cleared, read bank opposite the write bank.
    tick(x);
    chk_on = 1'b1;
    tick(x);
    tick(x);
    chk("reset_rd_bank", 32'(rd_bank_out), 32'(DB));
    chk("reset_frame_count", 32'(frame_count_out), 32'd0);
    rst_n_in = 1'b1;

    // Single write from core 0.
    req_valid_in = 4'b0001; req_addr_in[0] = 5'd5; req_data_in[0] = 4'hA;
    tick(x);
    chk("single_wr_en", 32'(wr_en_out), 32'd1);
    chk("single_wr_addr", 32'(wr_addr_out), 32'd5);
    chk("single_wr_data", 32'(wr_data_out), 32'hA);
    req_valid_in = '0;
    tick(x);

    // Round robin: everyone valid, then cores 1 and 3 only.
    for (int i = 0; i < 5; i++) begin
      rand_reqs(15);
      req_valid_in = 4'b1111;
      tick(x);
    end
    nx = 0;
    for (int i = 0; i < 6; i++) begin
      rand_reqs(15);
      req_valid_in = 4'b1010;
      tick(x);
      nx += x;
    end
    chk("rr_pair_no_idle", nx, 32'd6);

    // Reset mid-frame, 7 fresh transfers, reset again.
    rst_n_in = 1'b0; req_valid_in = '0;
    tick(x);
    rst_n_in = 1'b1;
    for (int i = 0; i < 7; i++) begin
      rand_reqs(15);
      req_valid_in = 4'b1111;
      tick(x);
    end
    rst_n_in = 1'b0; req_valid_in = '0;
    tick(x);
    rst_n_in = 1'b1;

    // Out-of-range pixel first, then 15 more transfers close the frame.
    rand_reqs(15);
    req_valid_in = 4'b1111;
    for (int i = 0; i < NC; i++) req_addr_in[2'(i)] = 5'd20;
    tick(x);
    chk("oor_wr_en", 32'(wr_en_out), 32'd0);
    f0 = m_frames;
    nx = 0;
    for (int i = 0; i < 200 && m_frames == f0; i++) begin
      rand_reqs(15);
      tick(x);
      nx += x;
    end
    chk("oor_fill_transfers", nx, 32'd15);

    // Vsync low: stall holds (double buffer), then a rising edge swaps.
    for (int i = 0; i < 10; i++) begin
      rand_reqs(15);
      req_valid_in = 4'b1111;
      tick(x);
    end
    req_valid_in = '0; vsync_in = 1'b1;
    tick(x);
    chk("swap_rd_bank", 32'(rd_bank_out), 32'd0);
    chk("swap_frame_done", 32'(frame_done_out), 32'(DB));
    chk("swap_frame_count", 32'(frame_count_out), 32'd1);
    vsync_in = 1'b0; req_valid_in = 4'b0001; req_addr_in[0] = 5'd3;
    tick(x);
    chk("msb_after_swap", 32'(wr_addr_out[AB]), 32'(DB));
    chk("wr_en_after_swap", 32'(wr_en_out), 32'd1);

    // Vsync rising on the final transfer cycle must not trigger the swap.
    for (int i = 0; i < 100 && m_cnt != PIX - 1; i++) begin
      rand_reqs(15);
      req_valid_in = 4'b0001;
      tick(x);
    end
    rand_reqs(15);
    req_valid_in = 4'b0001; vsync_in = 1'b1;
    tick(x);
    for (int i = 0; i < 3; i++) begin
      rand_reqs(15);
      req_valid_in = 4'b1111;
      tick(x);
    end
    chk("simul_no_swap_fc", 32'(frame_count_out), DB ? 32'd1 : 32'd2);
    vsync_in = 1'b0;
    tick(x);
    vsync_in = 1'b1;
    tick(x);
    chk("late_swap_fc", 32'(frame_count_out), 32'd2);
    chk("late_swap_rd_bank", 32'(rd_bank_out), 32'(DB));

    // Random traffic with vsync activity and occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_reqs(19);
      if ($urandom_range(0, 5) == 0) vsync_in = ~vsync_in;
      rst_n_in = ($urandom_range(0, 149) != 0);
      tick(x);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/framebuffer_arbiter.md
# framebuffer_arbiter

Shares the single framebuffer BRAM write port among `NUM_CORES` ray-marcher cores and sequences double-buffered frame swaps against display vsync. Sits between the cores' pixel outputs and the BRAM write port; the display's read side uses `rd_bank_out` as the MSB of its read address. Cores that finish early stall until the display's next vsync, so the display never shows a partially rendered frame.

## Interface
Parameters:
- `NUM_CORES`, 4: number of requesting cores, at least 1.
- `PIXELS`, 76800: pixels per frame (320x240).
- `ADDR_BITS`, 17: pixel address width; `2**ADDR_BITS` is at least `PIXELS`.

Ports:
- `clk_in`  in  1  single clock (VGA pixel clock domain).
- `rst_n_in`  in  1  reset; synchronous, active-low.
- `req_valid_in`  in  NUM_CORES  core i has a pixel to write.
- `req_addr_in`  in  NUM_CORES x ADDR_BITS  pixel address per core.
- `req_data_in`  in  NUM_CORES x 4  4-bit grayscale per core.
- `req_ready_out`  out  NUM_CORES  one-hot grant; a transfer occurs when valid and ready are both high.
- `vsync_in`  in  1  internal active-high vsync, before pin inversion.
- `wr_en_out`  out  1  BRAM write enable.
- `wr_addr_out`  out  ADDR_BITS+1  `{write bank, pixel address}`.
- `wr_data_out`  out  4  BRAM write data.
- `rd_bank_out`  out  1  bank the display reads.
- `frame_done_out`  out  1  one-cycle pulse at each frame completion or swap.
- `frame_count_out`  out  8  completed frames; wraps 255 -> 0.

## Operation
- **State machine:** two states, `RUN` and `WAIT_VSYNC`. Reset state is `RUN`.
- **Arbitration in `RUN`:** round-robin.
  - The grant is combinational from `req_valid_in` and pointer `ptr`.
  - It goes to the first valid index at or after `ptr`, modulo `NUM_CORES`.
  - After a transfer to core i, `ptr` becomes (i+1) mod `NUM_CORES`.
  - With no valid request, all ready signals are 0 and `ptr` holds.
  - At most one transfer per cycle.
- **`WAIT_VSYNC`:** `req_ready_out` is all 0.
- **Pixel counting:** `cnt` counts accepted transfers.
  - The transfer that brings `cnt` to `PIXELS` moves the state to `WAIT_VSYNC` and clears `cnt`.
- **Swap:** a vsync rising edge (`vsync_in` high and `vsync_d` low) seen in `WAIT_VSYNC` does all of the following:
  - toggles `bank`;
  - pulses `frame_done_out`;
  - increments `frame_count_out`;
  - returns the state to `RUN`.
- **Vsync edges in `RUN`** are ignored.
- **Bank mapping:** write bank = `bank`; `rd_bank_out` = `~bank`.
- **Out-of-range address:** a transfer with address at or above `PIXELS` is accepted and counted but not written (`wr_en_out` stays 0). This prevents deadlock.
- **Reset values:**
  - all outputs 0, except `rd_bank_out`, which is 1;
  - `bank` = 0, `ptr` = 0, `cnt` = 0, `vsync_d` = 0, state `RUN`;
  - reset asserted mid-frame discards all progress.

## Timing
- **Write latency:** a transfer at edge N appears as `wr_en_out`, `wr_addr_out` and `wr_data_out` valid during cycle N+1. All write outputs are registered.
- **Ready:** combinational from valid inputs and state. Cores must not make valid depend on ready.
- **State entry:** `WAIT_VSYNC` is entered at the edge of the last transfer. Ready is 0 from the next cycle onward.
- **Swap timing:** with the vsync edge detected in cycle N, `bank`, `frame_done_out` and `frame_count_out` update at edge N+1. Grants resume in the cycle after that.
- **Simultaneous events:** a vsync rising edge in the same cycle as the final transfer is not used; the block waits for the next rising edge.
- **Write ordering:** the final pixel's write is issued the cycle before any swap, so it always lands in the old write bank.

## Configuration
- **`FB_DOUBLE_BUFFER_EN` defined:** behaviour as above.
- **`FB_DOUBLE_BUFFER_EN` undefined:** single buffer.
  - No `WAIT_VSYNC` state and `vsync_in` is unused.
  - `bank` stays 0, so the `wr_addr_out` MSB is 0 and `rd_bank_out` is 0.
  - When `cnt` reaches `PIXELS`, it clears, `frame_done_out` pulses at the next edge, and `frame_count_out` increments.
  - Ready never stalls for a frame swap.

## Test plan
- **Reset and single write:** hold reset; all outputs 0 and `rd_bank_out` 1. Release; core 0 valid with addr 5, data 0xA -> `req_ready_out` = 0001 that cycle; next cycle `wr_en_out` 1, `wr_addr_out` = {0,5}, `wr_data_out` 0xA.
- **Round-robin:** all 4 cores valid continuously -> ready sequence 0001, 0010, 0100, 1000, 0001. Then only cores 1 and 3 valid -> they alternate with no idle cycles.
- **Double-buffer swap:** with `PIXELS`=16 and the macro on, after 16 transfers ready is 0. Vsync held low for 10 cycles -> no change. Vsync rises -> `rd_bank_out` 0, one-cycle `frame_done_out`, `frame_count_out` 1. The next write has `wr_addr_out` MSB 1.
- **Out-of-range address:** with `PIXELS`=16, a transfer with addr 20 -> `wr_en_out` stays 0. Fifteen further transfers trigger `WAIT_VSYNC`.
- **Reset mid-frame:** assert reset after 7 transfers -> `cnt` 0, `ptr` 0, `bank` 0. The next frame needs 16 fresh transfers.
- **Single-buffer mode:** with the macro off, after 16 transfers `frame_done_out` pulses without vsync. Ready stays high for a valid core, and the `wr_addr_out` MSB stays 0.
